// File: rtl/flow_collect_if.sv
// Producer/consumer handshake bundle for flow_collect: result input side and drain side.
interface flow_collect_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/flow_collect.sv
// Captures flow results into a FWFT FIFO and keeps sum/overflow/max over accepted words.
// Push visible one cycle later; in_ready drops only when full, independent of out_ready.
module flow_collect #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    flow_collect_if.slave    io,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] sum,
    output logic             sum_ovf,
    output logic [WIDTH-1:0] max_val
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovf;
    logic [WIDTH-1:0] r_max;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_sum_ext;

    // Flow control comes only from registered occupancy, so no input-to-output path exists.
    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = io.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && io.out_ready;
    assign w_sum_ext   = {1'b0, r_sum} + {1'b0, io.in_data};

    assign io.in_ready  = w_in_ready;
    assign io.out_valid = w_out_valid;
    assign io.out_data  = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign sum          = r_sum;
    assign sum_ovf      = r_ovf;
    assign max_val      = r_max;

    // Storage is left untouched by reset and clear; only the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= io.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sum    <= '0;
            r_ovf    <= 1'b0;
            r_max    <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sum    <= '0;
            r_ovf    <= 1'b0;
            r_max    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_sum <= w_sum_ext[WIDTH-1:0];
                r_ovf <= r_ovf | w_sum_ext[WIDTH];
                if (io.in_data > r_max) begin
                    r_max <= io.in_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_flow_collect.sv
// Randomized and directed bench for flow_collect against a queue-based reference model.
module tb_flow_collect;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [2:0]  count;
    logic [31:0] sum;
    logic        sum_ovf;
    logic [31:0] max_val;

    flow_collect_if #(.WIDTH(32)) io ();

    flow_collect #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .io      (io),
        .count   (count),
        .sum     (sum),
        .sum_ovf (sum_ovf),
        .max_val (max_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q [$];
    logic [31:0] m_sum;
    logic        m_ovf;
    logic [31:0] m_max;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sum = '0;
        m_ovf = 1'b0;
        m_max = '0;
    endtask

    task automatic check_state();
        check("count", 64'(count), 64'(q.size()));
        check("out_valid", 64'(io.out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(io.in_ready), 64'(q.size() != DEPTH));
        if (q.size() != 0) check("out_data", 64'(io.out_data), 64'(q[0]));
        check("sum", 64'(sum), 64'(m_sum));
        check("sum_ovf", 64'(sum_ovf), 64'(m_ovf));
        check("max_val", 64'(max_val), 64'(m_max));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
        bit     push;
        bit     pop;
        longint s;
        io.in_valid  = v;
        io.in_data   = d;
        io.out_ready = r;
        clear        = c;
        push = v && (q.size() < DEPTH);
        pop  = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (c) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d);
                s = longint'(m_sum) + longint'(d);
                if (s > 64'hFFFF_FFFF) m_ovf = 1'b1;
                m_sum = 32'(s);
                if (d > m_max) m_max = d;
            end
        end
        check_state();
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        io.in_valid  = 1'b1;
        io.in_data   = 32'd7;
        io.out_ready = 1'b0;
        model_reset();

        // 1. reset holds everything at zero despite in_valid
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(io.out_valid), 64'd0);
        check("rst_in_ready", 64'(io.in_ready), 64'd1);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_max", 64'(max_val), 64'd0);
        rst_n = 1'b1;
        step(1'b1, 32'd7, 1'b0, 1'b0);
        check("t1_out_data", 64'(io.out_data), 64'd7);
        check("t1_sum", 64'(sum), 64'd7);
        step(1'b0, 32'd0, 1'b0, 1'b1);

        // 2. fill, refuse when full, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check("t2_full_count", 64'(count), 64'd4);
        check("t2_full_in_ready", 64'(io.in_ready), 64'd0);
        step(1'b1, 32'd9, 1'b0, 1'b0);
        check("t2_refused_sum", 64'(sum), 64'd10);
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain_data", 64'(io.out_data), 64'(i));
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check("t2_empty", 64'(io.out_valid), 64'd0);

        // 3. simultaneous push/pop at partial and at full
        step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'd6, 1'b0, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b0);
        check("t3_count", 64'(count), 64'd2);
        check("t3_head", 64'(io.out_data), 64'd6);
        check("t3_sum", 64'(sum), 64'd29);
        step(1'b1, 32'd10, 1'b0, 1'b0);
        step(1'b1, 32'd11, 1'b0, 1'b0);
        step(1'b1, 32'd12, 1'b1, 1'b0);
        check("t3_full_pp_count", 64'(count), 64'd3);

        // 4. pointer wrap with occupancy at most 2
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'd100, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            check("t4_order", 64'(io.out_data), 64'(100 + i - 1));
            step(1'b1, 32'(100 + i), 1'b1, 1'b0);
        end
        check("t4_last", 64'(io.out_data), 64'd109);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("t4_max", 64'(max_val), 64'd109);

        // 5. wrapping sum and sticky overflow
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
        step(1'b1, 32'h20, 1'b1, 1'b0);
        check("t5_sum", 64'(sum), 64'h10);
        check("t5_ovf", 64'(sum_ovf), 64'd1);
        check("t5_max", 64'(max_val), 64'hFFFF_FFF0);
        step(1'b1, 32'h1, 1'b1, 1'b0);
        check("t5_ovf_sticky", 64'(sum_ovf), 64'd1);

        // 6. clear beats push/pop; async reset mid-cycle
        step(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'(40 + i), 1'b0, 1'b0);
        step(1'b1, 32'd55, 1'b1, 1'b1);
        check("t6_clr_count", 64'(count), 64'd0);
        check("t6_clr_sum", 64'(sum), 64'd0);
        check("t6_clr_ovf", 64'(sum_ovf), 64'd0);
        check("t6_clr_max", 64'(max_val), 64'd0);
        check("t6_clr_valid", 64'(io.out_valid), 64'd0);
        step(1'b1, 32'd70, 1'b0, 1'b0);
        step(1'b1, 32'd71, 1'b0, 1'b0);
        io.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_count", 64'(count), 64'd0);
        check("t6_arst_valid", 64'(io.out_valid), 64'd0);
        check("t6_arst_ready", 64'(io.in_ready), 64'd1);
        check("t6_arst_sum", 64'(sum), 64'd0);
        check("t6_arst_max", 64'(max_val), 64'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_state();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/flow_collect.md
# flow_collect

Result-capture stage downstream of the `flow` pipeline. It accepts each 32-bit result `C` that `flow` produces, qualified by a valid strobe, and buffers it in a small first-word-fall-through FIFO. A consumer drains the FIFO over a valid/ready handshake. The block also keeps running statistics over all accepted results: a wrapping sum, a sticky overflow flag and the unsigned maximum.

## Interface

- `WIDTH`, 32, data width; matches `flow` output `C`
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CW`, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `clear`  in  1  synchronous flush of FIFO and statistics
- `in_valid`  in  1  `in_data` holds a valid `flow` result this cycle
- `in_data`  in  WIDTH  result `C` from `flow`
- `in_ready`  out  1  FIFO can accept a word this cycle
- `out_valid`  out  1  `out_data` holds the oldest buffered word
- `out_data`  out  WIDTH  head of FIFO
- `out_ready`  in  1  consumer takes the head this cycle
- `count`  out  CW  number of buffered words, 0..DEPTH
- `sum`  out  WIDTH  sum of all accepted words, mod 2^WIDTH
- `sum_ovf`  out  1  sticky; set when any accumulation carried out of bit WIDTH-1
- `max_val`  out  WIDTH  unsigned maximum of accepted words

## Operation

- push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `in_ready` = (`count` != DEPTH), combinational from registered `count` only. It does not depend on `out_ready`: a full FIFO refuses input even when a pop occurs in the same cycle.
- `out_valid` = (`count` != 0). `out_data` = mem[rd_ptr], driven from registers (first-word fall-through). When empty, `out_data` is don't-care; the bench does not check it.
- Pointers `wr_ptr`, `rd_ptr` are log2(DEPTH) bits and wrap naturally at DEPTH.
- Push writes mem[wr_ptr] and increments `wr_ptr`. Pop increments `rd_ptr`.
- `count` update: push only +1; pop only −1; both 0; neither 0.
- Push and pop in the same cycle at non-empty, non-full occupancy: both succeed and `count` is unchanged.
- There is no bypass at empty: a word pushed while empty is visible on `out_data` the next cycle.
- Statistics update on push only:
  - `sum` ← `sum` + `in_data` (WIDTH bits, wraps).
  - `sum_ovf` ← `sum_ovf` | carry-out.
  - `max_val` ← (`in_data` > `max_val`) ? `in_data` : `max_val`, unsigned compare.
- `clear`, high at a rising edge:
  - pointers, `count`, `sum`, `sum_ovf` and `max_val` go to 0.
  - Any push or pop in that cycle is discarded; `clear` has priority.
  - Memory contents are not cleared.
- Control FSM: none beyond the counter. Occupancy states EMPTY (`count`=0), PARTIAL, FULL (`count`=DEPTH) follow solely from `count`.

## Timing

- `rst_n` low takes effect immediately, with no clock required. While `rst_n` is low:
  - `count`, pointers, `sum`, `sum_ovf`, `max_val` = 0.
  - `out_valid` = 0 and `in_ready` = 1.
- Reset mid-operation drops all buffered words. After deassertion, the first push is accepted at the first rising edge where `rst_n` is high.
- Latency is 1 cycle from a push edge to `out_valid`/`out_data` and to the updated `sum`/`max_val`.
- Sustained throughput is one word per cycle when `out_ready` is held high and occupancy is between 1 and DEPTH−1.
- All outputs are registered or derived combinationally from registers. There is no combinational path from `in_valid`/`out_ready` to any output.
- `flow` has no valid output. The integrating top asserts `in_valid` aligned to `flow`'s fixed pipeline latency after operands are applied; `flow_collect` does not compensate for that latency.

## Test plan

1. Reset: hold `rst_n`=0 with `in_valid`=1 and `in_data`=7 for 3 edges → `count`=0, `out_valid`=0, `in_ready`=1, `sum`=0, `max_val`=0. Release `rst_n`, push 7 → next cycle `out_valid`=1, `out_data`=7, `sum`=7.
2. Fill and order: push 1,2,3,4 with `out_ready`=0 → `count`=4 and `in_ready`=0. Push 9 while full → refused and `sum` stays 10. Drain with `out_ready`=1 → `out_data` sequence 1,2,3,4, then `out_valid`=0.
3. Simultaneous push and pop at `count`=2 (contents 5,6; push 8): → `count` stays 2, next `out_data`=6, `sum` +8. Then push and pop while full → the pop succeeds, the push is refused, and `count`=3.
4. Wrap-around: perform 10 push/pop pairs of values 100..109, never exceeding `count`=2 → output order 100..109 preserved across the pointer wrap, and `max_val`=109.
5. Arithmetic: push 0xFFFFFFF0 then 0x20 → `sum`=0x10, `sum_ovf`=1, `max_val`=0xFFFFFFF0. Push 0x1 → `sum_ovf` stays 1.
6. Clear: hold 3 words, then assert `clear` together with `in_valid`=1 and `out_ready`=1 → next cycle `count`=0, `sum`=0, `sum_ovf`=0, `max_val`=0, `out_valid`=0. Pulse `rst_n` low for 2 ns mid-cycle while holding 2 words → outputs reset immediately, before the next edge.
